// File: rtl/ppu_pixel_streamer_if.sv
// Valid/ready pixel stream carrying a 6-bit palette index with frame/line markers.
interface ppu_pixel_streamer_if;
    logic       m_valid;
    logic       m_ready;
    logic [5:0] m_data;
    logic       m_sof;
    logic       m_eol;

    modport master (
        output m_valid,
        output m_data,
        output m_sof,
        output m_eol,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_sof,
        input  m_eol,
        output m_ready
    );
endinterface

// File: rtl/ppu_pixel_streamer.sv
// Captures visible PPU pixels into a FWFT FIFO and streams whole frames; after an overflow the
// output resynchronises at the next frame start so no torn frame is ever followed without an SOF.
module ppu_pixel_streamer #(
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned WIDTH      = 256,
    parameter int unsigned HEIGHT     = 240
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_ce,
    input  logic [5:0]                   i_color,
    input  logic [8:0]                   i_cycle,
    input  logic [8:0]                   i_scanline,
    input  logic                         i_enable,
    ppu_pixel_streamer_if.master         m_stream,
    output logic [$clog2(FIFO_DEPTH):0]  o_fifo_level,
    output logic [31:0]                  o_frame_count,
    output logic [15:0]                  o_drop_count,
    output logic                         o_overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [8:0] WIDTH_L  = 9'(WIDTH);
    localparam logic [8:0] HEIGHT_L = 9'(HEIGHT);
    localparam logic [8:0] LAST_C   = 9'(WIDTH - 1);
    localparam logic [8:0] LAST_S   = 9'(HEIGHT - 1);

    typedef enum logic [1:0] {StWaitSof, StStream, StDrop} state_t;

    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    state_t        r_state;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic [31:0]   r_frame_count;
    logic [15:0]   r_drop_count;
    logic          r_overflow;

    logic w_pix;
    logic w_sof;
    logic w_eol;
    logic w_last;
    logic w_full;
    logic w_valid;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Asynchronous assertion, release aligned to the clock.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_pix   = i_ce && (i_cycle < WIDTH_L) && (i_scanline < HEIGHT_L);
    assign w_sof   = (i_cycle == 9'd0) && (i_scanline == 9'd0);
    assign w_eol   = (i_cycle == LAST_C);
    assign w_last  = w_eol && (i_scanline == LAST_S);
    assign w_full  = (r_level == FULL_LVL);
    assign w_valid = (r_level != '0);
    assign w_pop   = w_valid && m_stream.m_ready;

    always_comb begin
        w_push = 1'b0;
        w_drop = 1'b0;
        if (w_pix) begin
            unique case (r_state)
                StWaitSof: w_push = w_sof && i_enable && !w_full;
                StStream: begin
                    w_push = !w_full;
                    w_drop = w_full;
                end
                StDrop: begin
                    w_push = w_sof && i_enable && !w_full;
                    w_drop = !w_sof;
                end
                default: begin
                    w_push = 1'b0;
                    w_drop = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state       <= StWaitSof;
            r_frame_count <= '0;
            r_drop_count  <= '0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 16'hFFFF) begin
                    r_drop_count <= r_drop_count + 16'd1;
                end
            end
            if (w_push && w_last) begin
                r_frame_count <= r_frame_count + 32'd1;
            end
            unique case (r_state)
                StWaitSof: begin
                    if (w_push && !w_last) r_state <= StStream;
                end
                StStream: begin
                    if (w_drop) begin
                        r_state <= StDrop;
                    end else if (w_push && w_last) begin
                        r_state <= StWaitSof;
                    end
                end
                StDrop: begin
                    // A frame start either resumes streaming or parks until a usable SOF.
                    if (w_pix && w_sof) begin
                        r_state <= (w_push && !w_last) ? StStream : StWaitSof;
                    end
                end
                default: r_state <= StWaitSof;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_sof, w_eol, i_color};
        end
    end

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    assign m_stream.m_valid = w_valid;
    assign {m_stream.m_sof, m_stream.m_eol, m_stream.m_data} = w_valid ? r_mem[r_rptr] : 8'h00;

    assign o_fifo_level  = r_level;
    assign o_frame_count = r_frame_count;
    assign o_drop_count  = r_drop_count;
    assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_ppu_pixel_streamer.sv
// Directed bench for ppu_pixel_streamer using a reduced 16x12 frame and a 16-entry FIFO.
module tb_ppu_pixel_streamer;

    localparam int W = 16;
    localparam int H = 12;
    localparam int D = 16;
    localparam int NPIX = W * H;
    localparam int BIG = 1000000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ce;
    logic [5:0] color;
    logic [8:0] cycle;
    logic [8:0] scanline;
    logic       enable;
    logic [4:0] fifo_level;
    logic [31:0] frame_count;
    logic [15:0] drop_count;
    logic       overflow;

    ppu_pixel_streamer_if u_if ();

    ppu_pixel_streamer #(
        .FIFO_DEPTH (D),
        .WIDTH      (W),
        .HEIGHT     (H)
    ) u_dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_ce          (ce),
        .i_color       (color),
        .i_cycle       (cycle),
        .i_scanline    (scanline),
        .i_enable      (enable),
        .m_stream      (u_if),
        .o_fifo_level  (fifo_level),
        .o_frame_count (frame_count),
        .o_drop_count  (drop_count),
        .o_overflow    (overflow)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int          rdy_mode = 1;
    int unsigned n_unstable = 0;
    logic [7:0]  rx_q[$];

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Consumer ready pattern: 0 = held low, 1 = held high, 2 = high one clock in three.
    initial begin
        int k = 0;
        u_if.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       u_if.m_ready = 1'b0;
                1:       u_if.m_ready = 1'b1;
                default: u_if.m_ready = (k % 3 == 0);
            endcase
            k++;
        end
    end

    // Stream monitor: records accepted words and flags any change during a stall.
    initial begin
        logic       prev_stall = 1'b0;
        logic [7:0] prev_word = 8'h00;
        logic [7:0] word;
        forever begin
            @(negedge clk);
            word = {u_if.m_sof, u_if.m_eol, u_if.m_data};
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (!u_if.m_valid || word != prev_word)) n_unstable++;
                if (u_if.m_valid && u_if.m_ready) rx_q.push_back(word);
                prev_stall = u_if.m_valid && !u_if.m_ready;
                prev_word = word;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Drives lines first_line..H+1 with 4 blanking dots per line, ce every clock.
    task automatic ppu_run(input int first_line, input int en_line, input int max_px);
        int n = 0;
        for (int s = first_line; s < H + 2; s++) begin
            for (int c = 0; c < W + 4; c++) begin
                if (n < max_px) begin
                    @(posedge clk);
                    #1;
                    ce       = 1'b1;
                    cycle    = 9'(c);
                    scanline = 9'(s);
                    color    = 6'((c ^ s) & 63);
                    enable   = (s >= en_line);
                    n++;
                end
            end
        end
        @(posedge clk);
        #1;
        ce = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (fifo_level != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({tag, ".drained"}, fifo_level, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Received words must be pixels 0,1,2.. of a frame in raster order.
    task automatic check_stream(input string tag, output int nsof, output int neol);
        int bad = 0;
        nsof = 0;
        neol = 0;
        for (int i = 0; i < rx_q.size(); i++) begin
            int s = i / W;
            int c = i % W;
            logic [7:0] e;
            e = {(i == 0), (c == W - 1), 6'((c ^ s) & 63)};
            if (rx_q[i] !== e) bad++;
            if (rx_q[i][7]) nsof++;
            if (rx_q[i][6]) neol++;
        end
        check({tag, ".order_errs"}, bad, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int nsof;
        int neol;
        int got_words;
        reset_n  = 1'b0;
        ce       = 1'b0;
        color    = '0;
        cycle    = '0;
        scanline = '0;
        enable   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.valid", u_if.m_valid, 0);
        check("rst.data", u_if.m_data, 0);
        check("rst.level", fifo_level, 0);
        check("rst.frames", frame_count, 0);
        check("rst.drops", drop_count, 0);
        check("rst.ovf", overflow, 0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Full frame, consumer always ready.
        rx_q.delete();
        ppu_run(0, 0, BIG);
        drain("t1");
        check_stream("t1", nsof, neol);
        check("t1.words", rx_q.size(), NPIX);
        check("t1.sof", nsof, 1);
        check("t1.eol", neol, H);
        check("t1.frames", frame_count, 1);
        check("t1.drops", drop_count, 0);
        check("t1.ovf", overflow, 0);

        // Enable rises at line 5: that frame is skipped, the next one is captured whole.
        rx_q.delete();
        ppu_run(0, 5, BIG);
        check("t2.skip_words", rx_q.size(), 0);
        check("t2.skip_level", fifo_level, 0);
        ppu_run(0, 0, BIG);
        drain("t2");
        check_stream("t2", nsof, neol);
        check("t2.words", rx_q.size(), NPIX);
        check("t2.sof", nsof, 1);
        check("t2.frames", frame_count, 2);

        // Consumer stalled for a whole frame: 16 buffered, remaining 176 dropped.
        do_reset();
        rdy_mode = 0;
        rx_q.delete();
        ppu_run(0, 0, BIG);
        check("t3.level", fifo_level, D);
        check("t3.valid", u_if.m_valid, 1);
        check("t3.ovf", overflow, 1);
        check("t3.drops", drop_count, NPIX - D);
        check("t3.frames", frame_count, 0);
        check("t3.words", rx_q.size(), 0);

        // Release the consumer: buffered words drain intact, next frame recovers with SOF.
        rdy_mode = 1;
        drain("t5a");
        check_stream("t5a", nsof, neol);
        check("t5a.words", rx_q.size(), D);
        check("t5a.sof", nsof, 1);
        rx_q.delete();
        ppu_run(0, 0, BIG);
        drain("t5b");
        check_stream("t5b", nsof, neol);
        check("t5b.words", rx_q.size(), NPIX);
        check("t5b.first_sof", (rx_q.size() > 0) ? rx_q[0][7] : 1'b0, 1);
        check("t5b.frames", frame_count, 1);
        check("t5b.drops", drop_count, NPIX - D);
        check("t5b.ovf", overflow, 1);

        // Consumer ready one clock in three: overflow occurs, nothing lost before it.
        do_reset();
        rdy_mode = 2;
        n_unstable = 0;
        rx_q.delete();
        ppu_run(0, 0, BIG);
        drain("t4");
        got_words = rx_q.size();
        check_stream("t4", nsof, neol);
        check("t4.stable", n_unstable, 0);
        check("t4.ovf", overflow, 1);
        check("t4.frames", frame_count, 0);
        check("t4.min_words", (got_words >= D), 1);
        check("t4.drops", drop_count, NPIX - got_words);

        // Reset mid-frame with 10 words buffered.
        rdy_mode = 0;
        rx_q.delete();
        ppu_run(0, 0, 10);
        check("t6.level_pre", fifo_level, 10);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6.valid", u_if.m_valid, 0);
        check("t6.level", fifo_level, 0);
        check("t6.frames", frame_count, 0);
        check("t6.drops", drop_count, 0);
        check("t6.ovf", overflow, 0);
        repeat (3) @(posedge clk);
        #1;
        rdy_mode = 1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rx_q.delete();
        ppu_run(1, 0, BIG);
        check("t6.rest_words", rx_q.size(), 0);
        ppu_run(0, 0, BIG);
        drain("t6");
        check_stream("t6", nsof, neol);
        check("t6.words", rx_q.size(), NPIX);
        check("t6.first_sof", (rx_q.size() > 0) ? rx_q[0][7] : 1'b0, 1);
        check("t6.frames_after", frame_count, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
